// File: rtl/mux_eight_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_eight_arbiter
// Purpose  : Round-robin arbiter with hold-limit rotation driving the select
//            of the eight-input mux_eight datapath.
// Revision : 1.0 - initial release
// ============================================================================
module mux_eight_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       expire
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] c_hold_last = HW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_gnt;
    logic [7:0]      w_gnt_nxt;
    logic [2:0]      r_sel;
    logic [2:0]      w_sel_nxt;
    logic [2:0]      r_ptr;
    logic [2:0]      w_ptr_nxt;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_nxt;
    logic            w_expire;
    logic [2:0]      w_ptr_inc;
    logic [3:0]      w_win_idle;
    logic [3:0]      w_win_rel;
    logic [3:0]      w_win_exp;

    // Returns {found, index}; the lowest offset from p with a request wins.
    function automatic logic [3:0] f_arbitrate(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_expire    = 1'b0;
        w_ptr_inc   = r_sel + 3'd1;
        w_win_idle  = f_arbitrate(req, r_ptr);
        w_win_rel   = f_arbitrate(req & ~(8'd1 << r_sel), w_ptr_inc);
        w_win_exp   = f_arbitrate(req, w_ptr_inc);

        case (r_state)
            ST_IDLE: begin
                if (w_win_idle[3]) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = 8'd1 << w_win_idle[2:0];
                    w_sel_nxt   = w_win_idle[2:0];
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (!req[r_sel]) begin
                    // Release takes precedence over a coincident hold-limit expiry.
                    w_ptr_nxt  = w_ptr_inc;
                    w_hold_nxt = '0;
                    if (w_win_rel[3]) begin
                        w_gnt_nxt = 8'd1 << w_win_rel[2:0];
                        w_sel_nxt = w_win_rel[2:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 8'd0;
                    end
                end else if (r_hold_cnt == c_hold_last) begin
                    // The current owner is still requesting, so a winner always exists.
                    w_expire   = 1'b1;
                    w_ptr_nxt  = w_ptr_inc;
                    w_hold_nxt = '0;
                    w_gnt_nxt  = 8'd1 << w_win_exp[2:0];
                    w_sel_nxt  = w_win_exp[2:0];
                end else begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 8'd0;
            r_sel      <= 3'd0;
            r_ptr      <= 3'd0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign sel    = r_sel;
    assign busy   = |r_gnt;
    assign expire = w_expire;

endmodule
`default_nettype wire

// File: doc/mux_eight_arbiter.md
# mux_eight_arbiter

Round-robin arbiter and select controller for the eight-input, one-bit `mux_eight` datapath. It shares the mux among eight requesters, one per data input I0..I7. It grants exactly one requester at a time and drives the mux select `s` from the granted index. A hold limit forces rotation so that no requester can monopolise the mux.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may last before a forced rotation. Legal values are 1 to 256.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, 8: request vector. `req[i]` asks for mux input I*i*.
- `gnt`, output, 8: one-hot grant, registered. All zero when idle.
- `sel`, output, 3: mux select, registered. Connects directly to `mux_eight.s`. Equals the index of the set `gnt` bit.
- `busy`, output, 1: high whenever any `gnt` bit is set.
- `expire`, output, 1: one-cycle pulse marking the last cycle of a grant ended by the hold limit.

## Operation

State machine with two states, IDLE and GRANT. Internal registers:
- `ptr[2:0]`: highest-priority index.
- `hold_cnt`: width `$clog2(MAX_HOLD)+1`.

Arbitration function:
- Scan indices `ptr`, `ptr+1`, …, `ptr+7`, all mod 8 (3-bit wrap).
- The first index with an eligible request wins.

IDLE:
- Outputs: `gnt=0`, `busy=0`, `expire=0`. `sel` holds its last value.
- If `|req`: winner = arbitrate over `req`. Load `gnt`/`sel`, clear `hold_cnt`, move to GRANT.

GRANT (current index c = `sel`):
- If `req[c]==1` and `hold_cnt < MAX_HOLD-1`: stay, `hold_cnt++`.
- Release, when `req[c]==0`:
  - `ptr <= c+1`.
  - Arbitrate over `req` with bit c masked.
  - Winner exists: grant it next cycle, `hold_cnt <= 0`. Otherwise go to IDLE.
- Forced expiry, when `req[c]==1` and `hold_cnt == MAX_HOLD-1`:
  - `expire=1` in this cycle (combinational from state).
  - `ptr <= c+1`.
  - Arbitrate over unmasked `req`, so c has lowest priority and is re-granted only if it is the sole requester.
  - Next grant starts next cycle with `hold_cnt <= 0`.
- Release and expiry on the same cycle: release wins, `expire=0`.

Further rules:
- Back-to-back grants: no idle cycle inserted between a release/expiry and the next grant.
- Requests that change during a grant do not affect `gnt` until that grant ends.
- `MAX_HOLD=1`: every grant lasts exactly one cycle. `expire` is high on every granted cycle whose requester is still requesting.

## Timing

Reset values (next edge with `rst=1`, regardless of state or `req`):
- `gnt=8'h00`, `sel=3'd0`, `busy=0`, `expire=0`.
- `ptr=0`, `hold_cnt=0`, state IDLE.

Reset and grant timing:
- Reset mid-grant drops `gnt` at that edge.
- After `rst` deasserts, the first grant can appear one cycle later.
- Grant latency from IDLE: `req` sampled at edge t gives `gnt`/`sel`/`busy` valid after edge t (visible in cycle t+1).
- A grant lasts at most `MAX_HOLD` cycles.

Release timing:
- `req[c]` low at edge t means `gnt[c]` is low after edge t.
- The successor's grant is visible after the same edge t.

Mux path and invariants:
- `sel` is stable for the whole grant. The mux output `result` reflects I*sel* combinationally during every `busy` cycle.
- Invariants checked every cycle:
  - `$onehot0(gnt)`
  - `busy == |gnt`
  - `gnt == (busy << sel)`
  - `expire` implies `busy`

## Test plan

1. Reset: `rst=1` for 2 cycles with `req=8'hFF`. Required: `gnt=0`, `sel=0`, `busy=0` throughout. One cycle after `rst` drops, `gnt=8'h01`, `sel=0`.
2. Single requester: `req=8'h10` for 3 cycles, then 0. Required: `gnt=8'h10`, `sel=4` for 3 cycles, then `gnt=0`, `busy=0`, `expire` never high.
3. Full contention, `MAX_HOLD=4`, `req=8'hFF` held. Required: grants 0,1,2,…,7,0, each exactly 4 cycles, no gap. `expire` pulses on the 4th cycle of each grant.
4. Wrap-around: after a grant to index 6 ends, `req=8'h81`. Required: grant 7 first, then 0 after 7 releases. `sel` goes 7 → 0.
5. Sole requester expiry, `MAX_HOLD=4`: `req=8'h04` held 10 cycles. Required: `gnt=8'h04` continuous for 10 cycles. `expire` high on cycles 4 and 8. `busy` never drops.
6. Reset mid-grant plus simultaneous event: `req[2]` drops exactly on the cycle `hold_cnt=MAX_HOLD-1`. Required: `expire=0`, grant passes to the next requester. A separate run asserts `rst` during a grant to index 5. Required: `gnt=0`, `sel=0` at the next edge, and the next grant restarts from index 0.
